// File: rtl/rv32ima_pkg.sv
// rv32ima_pkg: shared types for the memory path of the rv32ima core.
//   mem_width_t  - access width carried alongside every memory request
//   ram_state_t  - status reported by the RAM each cycle
//   arb_state_t  - mem_arbiter FSM states
package rv32ima_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_width_t;

  typedef enum logic [1:0] {
    RAM_FREE = 2'd0,
    RAM_BUSY = 2'd1,
    RAM_DATA = 2'd2
  } ram_state_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req   - request vector, one bit per channel
//   ptr   - channel with highest priority this cycle
//   valid - at least one request is set
//   idx   - first requesting channel found scanning upward from ptr,
//           wrapping from NUM_REQ-1 to 0
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // ptr and i are both below NUM_REQ, so one subtraction wraps the sum.
      sum = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
        sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one RAM port among NUM_REQ
// requesters (channel 0 = dmem, 1 = imem in the default core).
//   clk, nrst          - clock, asynchronous active-low reset
//   req_ren/req_wen    - per-channel read / write request (both = write)
//   req_addr/req_store/req_width - per-channel request payload
//   req_load           - per-channel load data, non-zero only on a read hit
//   req_hit / req_err  - one-cycle completion / timeout-abort pulse
//   ram_*              - shared RAM port; ram_state==RAM_DATA ends an access
module mem_arbiter
  import rv32ima_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic       [NUM_REQ-1:0]              req_ren,
  input  logic       [NUM_REQ-1:0]              req_wen,
  input  logic       [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic       [NUM_REQ-1:0][DATA_W-1:0]  req_store,
  input  mem_width_t [NUM_REQ-1:0]              req_width,
  output logic       [NUM_REQ-1:0][DATA_W-1:0]  req_load,
  output logic       [NUM_REQ-1:0]              req_hit,
  output logic       [NUM_REQ-1:0]              req_err,
  output logic       [ADDR_W-1:0]               ram_addr,
  output logic       [DATA_W-1:0]               ram_store,
  output mem_width_t                            ram_width,
  output logic                                  ram_ren,
  output logic                                  ram_wen,
  input  logic       [DATA_W-1:0]               ram_load,
  input  ram_state_t                            ram_state
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  grant_q;
  logic              op_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] store_q;
  mem_width_t        width_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [NUM_REQ-1:0] eligible;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               is_busy;
  logic               done_hit;
  logic               done_err;
  logic               done;
  logic [IDX_W-1:0]   grant_next;

  assign eligible = req_ren | req_wen;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (eligible),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign is_busy  = (state_q == ARB_BUSY);
  assign done_hit = is_busy && (ram_state == RAM_DATA);
  // RAM_DATA wins over a timeout landing in the same cycle.
  assign done_err = is_busy && (ram_state != RAM_DATA) &&
                    (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign done     = done_hit || done_err;
  assign grant_next = (grant_q == IDX_LAST) ? '0 : grant_q + IDX_W'(1);

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (pick_valid) state_d = ARB_BUSY;
      ARB_BUSY: if (done)       state_d = ARB_IDLE;
      default:                  state_d = ARB_IDLE;
    endcase
  end

  // Request latch, timeout counter and round-robin pointer
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      store_q    <= '0;
      width_q    <= MEM_BYTE;
      cnt_q      <= '0;
    end else if (state_q == ARB_IDLE) begin
      if (pick_valid) begin
        grant_q    <= pick_idx;
        op_write_q <= req_wen[pick_idx];
        addr_q     <= req_addr[pick_idx];
        store_q    <= req_store[pick_idx];
        width_q    <= req_width[pick_idx];
        cnt_q      <= '0;
      end
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) begin
        rr_ptr_q <= grant_next;
      end
    end
  end

  // Outputs: everything is zero outside BUSY, so reset drops the RAM
  // enables immediately through the asynchronous state reset.
  always_comb begin
    req_load  = '0;
    req_hit   = '0;
    req_err   = '0;
    ram_addr  = '0;
    ram_store = '0;
    ram_width = MEM_BYTE;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    if (is_busy) begin
      ram_addr  = addr_q;
      ram_store = store_q;
      ram_width = width_q;
      if (done_hit) begin
        req_hit[grant_q] = 1'b1;
        if (!op_write_q) begin
          req_load[grant_q] = ram_load;
        end
      end else if (done_err) begin
        req_err[grant_q] = 1'b1;
      end else begin
        ram_wen = op_write_q;
        ram_ren = !op_write_q;
      end
    end
  end

endmodule
